// File: rtl/pipeline_hazard_sequencer.sv
// rtl/pipeline_hazard_sequencer.sv - stall/flush sequencer for the 5-stage pipeline (optional perf counters: HAZARD_PERF_CNT_EN)
module pipeline_hazard_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_use_hazard,
  input  logic             branch_taken,
  input  logic             imem_busywait,
  input  logic             dmem_busywait,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             id_ex_enable,
  output logic             ex_mem_enable,
  output logic             mem_wb_enable,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [2:0]       seq_state,
  output logic             timeout_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic [CNT_W-1:0] load_use_count
`endif
);

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    IMEM_WAIT = 3'd1,
    MEM_STALL = 3'd2,
    REDIRECT  = 3'd3,
    FAULT     = 3'd4
  } state_t;

  localparam logic [16:0] TIMEOUT_L = 17'(TIMEOUT_CYCLES);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535 || CNT_W < 1) begin : g_param_check
    $error("pipeline_hazard_sequencer: parameter out of range");
  end

  state_t      state_q, state_d;
  logic [15:0] wd_q;
  logic [16:0] wd_inc;
  logic        timeout_q;
  logic        busy;
  logic        timeout_hit;

  assign busy        = imem_busywait | dmem_busywait;
  assign wd_inc      = {1'b0, wd_q} + 17'd1;
  // Watchdog fires on the busy cycle that brings the count up to the limit.
  assign timeout_hit = busy && (state_q != FAULT) && (wd_inc == TIMEOUT_L);
  assign seq_state   = state_q;
  assign timeout_err = timeout_q;

  // Decode stage enables/flushes from current state and live hazard inputs.
  always_comb begin
    pc_enable     = 1'b1;
    if_id_enable  = 1'b1;
    id_ex_enable  = 1'b1;
    ex_mem_enable = 1'b1;
    mem_wb_enable = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    state_d       = state_q;
    case (state_q)
      RUN, IMEM_WAIT, MEM_STALL: begin
        if (dmem_busywait) begin
          // Freeze everything; EX/ID contents (incl. branch/load-use) stay valid.
          {pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable} = 5'b00000;
          state_d = MEM_STALL;
        end else if (branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          state_d     = imem_busywait ? REDIRECT : RUN;
        end else if (load_use_hazard) begin
          pc_enable    = 1'b0;
          if_id_enable = 1'b0;
          id_ex_flush  = 1'b1;
          state_d      = RUN;
        end else if (imem_busywait) begin
          pc_enable    = 1'b0;
          if_id_enable = 1'b0;
          id_ex_flush  = 1'b1;
          state_d      = IMEM_WAIT;
        end else begin
          state_d = RUN;
        end
      end
      REDIRECT: begin
        if (dmem_busywait) begin
          {pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable} = 5'b00000;
        end else if (imem_busywait) begin
          pc_enable    = 1'b0;
          if_id_enable = 1'b0;
          id_ex_flush  = 1'b1;
        end else begin
          // Stale fetch has landed: drop it; the target is fetched next cycle.
          pc_enable    = 1'b0;
          if_id_enable = 1'b0;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          state_d      = RUN;
        end
      end
      FAULT: begin
        {pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable} = 5'b00000;
      end
      default: state_d = RUN;
    endcase
    if (timeout_hit) state_d = FAULT;
    if (reset) begin
      {pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable} = 5'b00000;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  // State register, watchdog counter and sticky fault flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      wd_q      <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (!busy) wd_q <= 16'd0;
      else if (wd_q != 16'hFFFF) wd_q <= wd_inc[15:0];
      if (timeout_hit) timeout_q <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic lu_applied;
  assign lu_applied = !reset && !dmem_busywait && !branch_taken && load_use_hazard &&
                      (state_q == RUN || state_q == IMEM_WAIT || state_q == MEM_STALL);

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles   <= '0;
      flush_events   <= '0;
      load_use_count <= '0;
    end else begin
      if (!pc_enable && state_q != FAULT && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
      if (if_id_flush && flush_events != '1) flush_events <= flush_events + 1'b1;
      if (lu_applied && load_use_count != '1) load_use_count <= load_use_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// tb/tb_pipeline_hazard_sequencer.sv - table-driven bench for pipeline_hazard_sequencer
module tb_pipeline_hazard_sequencer;

  logic       clk = 1'b0;
  logic       reset, lu, br, im, dm;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, to_err;
  logic [2:0] st;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events, load_use_count;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_hazard_sequencer #(.TIMEOUT_CYCLES(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .load_use_hazard(lu), .branch_taken(br),
    .imem_busywait(im), .dmem_busywait(dm),
    .pc_enable(pc_en), .if_id_enable(ifid_en), .id_ex_enable(idex_en),
    .ex_mem_enable(exmem_en), .mem_wb_enable(memwb_en),
    .if_id_flush(ifid_fl), .id_ex_flush(idex_fl), .seq_state(st), .timeout_err(to_err)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events), .load_use_count(load_use_count)
`endif
  );

  typedef struct {
    logic       rst, lu, br, im, dm;
    logic [4:0] en;
    logic [1:0] fl;
    logic       chk_st;
    logic [2:0] st;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic l, input logic b, input logic i, input logic d,
                     input logic [4:0] e, input logic [1:0] f, input logic c, input logic [2:0] s);
    vec_t v;
    v.rst = r; v.lu = l; v.br = b; v.im = i; v.dm = d;
    v.en = e; v.fl = f; v.chk_st = c; v.st = s;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic l, input logic b, input logic i, input logic d);
    reset = r; lu = l; br = b; im = i; dm = d;
  endtask

  // Inputs change #1 after posedge; outputs are sampled on negedge.
  task automatic step(input logic r, input logic l, input logic b, input logic i, input logic d);
    @(posedge clk); #1;
    drive(r, l, b, i, d);
    @(negedge clk);
  endtask

  initial begin
    // reset lu br im dm | en{pc,ifid,idex,exmem,memwb} fl{ifid,idex} chk st
    add(1,0,0,0,0, 5'b00000, 2'b11, 0, 3'd0);
    add(1,0,0,0,0, 5'b00000, 2'b11, 1, 3'd0);
    add(0,0,0,0,0, 5'b11111, 2'b00, 1, 3'd0);
    add(0,1,0,0,0, 5'b00111, 2'b01, 1, 3'd0); // load-use
    add(0,0,0,0,0, 5'b11111, 2'b00, 1, 3'd0);
    add(0,0,1,0,1, 5'b00000, 2'b00, 1, 3'd0); // dmem wait beats branch
    add(0,0,1,0,1, 5'b00000, 2'b00, 1, 3'd2);
    add(0,0,1,0,1, 5'b00000, 2'b00, 1, 3'd2);
    add(0,0,1,0,0, 5'b11111, 2'b11, 1, 3'd2); // branch taken after wait
    add(0,0,0,0,0, 5'b11111, 2'b00, 1, 3'd0);
    add(0,0,1,1,0, 5'b11111, 2'b11, 1, 3'd0); // branch with fetch in flight
    add(0,0,0,1,0, 5'b00111, 2'b01, 1, 3'd3);
    add(0,0,0,1,0, 5'b00111, 2'b01, 1, 3'd3);
    add(0,0,0,0,0, 5'b00111, 2'b11, 1, 3'd3); // discard stale fetch
    add(0,0,0,0,0, 5'b11111, 2'b00, 1, 3'd0);
    add(0,0,0,1,0, 5'b00111, 2'b01, 1, 3'd0); // imem wait only
    add(0,0,0,0,0, 5'b11111, 2'b00, 1, 3'd1);
    add(0,0,0,0,0, 5'b11111, 2'b00, 1, 3'd0);
    add(0,1,0,1,0, 5'b00111, 2'b01, 1, 3'd0); // load-use beats imem
    add(0,0,0,0,0, 5'b11111, 2'b00, 1, 3'd0);
    add(0,0,1,1,0, 5'b11111, 2'b11, 1, 3'd0); // redirect then dmem wait
    add(0,0,1,1,1, 5'b00000, 2'b00, 1, 3'd3); // branch ignored in REDIRECT
    add(0,0,1,0,0, 5'b00111, 2'b11, 1, 3'd3);
    add(0,0,0,0,0, 5'b11111, 2'b00, 1, 3'd0);

    drive(1, 0, 0, 0, 0);
    #1;
    for (int k = 0; k < vecs.size(); k++) begin
      if (k == 0) @(negedge clk);
      else step(vecs[k].rst, vecs[k].lu, vecs[k].br, vecs[k].im, vecs[k].dm);
      check($sformatf("v%0d_en", k), {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, {27'd0, vecs[k].en});
      check($sformatf("v%0d_fl", k), {30'd0, ifid_fl, idex_fl}, {30'd0, vecs[k].fl});
      if (vecs[k].chk_st) check($sformatf("v%0d_st", k), {29'd0, st}, {29'd0, vecs[k].st});
      if (vecs[k].chk_st) check($sformatf("v%0d_to", k), {31'd0, to_err}, 32'd0);
    end

    // Watchdog: imem stuck, limit 4.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    check("wd_before_3", {31'd0, to_err}, 32'd0);
    step(0, 0, 0, 1, 0);
    check("wd_before_4", {31'd0, to_err}, 32'd0);
    step(0, 0, 0, 1, 0);
    check("wd_err", {31'd0, to_err}, 32'd1);
    check("wd_state", {29'd0, st}, 32'd4);
    check("wd_en", {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 32'd0);
    check("wd_fl", {30'd0, ifid_fl, idex_fl}, 32'd0);
    step(0, 1, 1, 0, 0);
    check("fault_hold_st", {29'd0, st}, 32'd4);
    check("fault_hold_err", {31'd0, to_err}, 32'd1);
    check("fault_hold_en", {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 32'd0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("fault_rst_err", {31'd0, to_err}, 32'd0);
    check("fault_rst_st", {29'd0, st}, 32'd0);
    check("fault_rst_en", {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 32'h1f);

`ifdef HAZARD_PERF_CNT_EN
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    check("perf_load_use", load_use_count, 32'd3);
    check("perf_flush", flush_events, 32'd1);
    check("perf_stall", stall_cycles, 32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_sequencer.md
Name: pipeline_hazard_sequencer

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline. Sits beside the ID-stage forwarding/hazard logic.
- Merges four hazard sources into per-stage register enables and bubble/flush controls:
  - load-use stall from ID
  - branch/jump redirect from EX
  - instruction-memory busywait
  - data-memory busywait
- An FSM tracks multi-cycle conditions: memory waits, and a redirect that overlaps an in-flight fetch. A watchdog flags a hung memory.

Parameters:
- TIMEOUT_CYCLES, 255: consecutive busywait cycles before fault; legal range 1..65535.
- CNT_W, 32: width of the performance counters (optional feature only).

Ports:
- clk  input  1  pipeline clock
- reset  input  1  synchronous, active-high reset
- load_use_hazard  input  1  ID instruction needs the result of the load currently in EX
- branch_taken  input  1  EX resolved a taken branch/jump; PC mux selects the target
- imem_busywait  input  1  instruction fetch not yet complete
- dmem_busywait  input  1  data access in MEM not yet complete
- pc_enable  output  1  PC register load
- if_id_enable  output  1  IF/ID register load
- id_ex_enable  output  1  ID/EX register load
- ex_mem_enable  output  1  EX/MEM register load
- mem_wb_enable  output  1  MEM/WB register load
- if_id_flush  output  1  load NOP into IF/ID (takes priority over if_id_enable)
- id_ex_flush  output  1  load NOP into ID/EX (NOP_sel)
- seq_state  output  3  current FSM state, for debug
- timeout_err  output  1  sticky watchdog fault

Behaviour:
- Control outputs are combinational from the registered state and the current inputs, so a stall acts in the same cycle. The state, watchdog counter and timeout_err are registered.
- Reset, synchronous: state=RUN, counter=0, timeout_err=0. While reset=1:
  - all enables = 0
  - if_id_flush = id_ex_flush = 1
- States: RUN=0, IMEM_WAIT=1, MEM_STALL=2, REDIRECT=3, FAULT=4.
- Priority in RUN, IMEM_WAIT and MEM_STALL, highest first: dmem_busywait, then branch_taken, then load_use_hazard, then imem_busywait. Default: everything enabled, no flush.
- dmem_busywait=1:
  - all five enables = 0, no flushes
  - next state = MEM_STALL
  - branch_taken and load_use are ignored; they stay valid because EX and ID are frozen.
- branch_taken=1:
  - all enables = 1, if_id_flush = 1, id_ex_flush = 1; PC loads the target.
  - If imem_busywait=1 in the same cycle, next state = REDIRECT (a stale fetch is in flight); otherwise RUN.
- load_use_hazard=1:
  - pc_enable = if_id_enable = 0, id_ex_flush = 1; EX/MEM and MEM/WB enabled.
  - Next state = RUN. Lasts exactly the cycles the input is high, normally 1.
- imem_busywait only:
  - pc_enable = if_id_enable = 0, id_ex_flush = 1; downstream stages drain.
  - Next state = IMEM_WAIT.
- MEM_STALL / IMEM_WAIT: identical decode to RUN; return to RUN when neither busywait is asserted.
- REDIRECT:
  - dmem_busywait=1: all enables = 0, hold in REDIRECT.
  - Otherwise, while imem_busywait=1: pc_enable = if_id_enable = 0, id_ex_flush = 1.
  - First cycle with imem_busywait=0: discard the stale instruction (if_id_flush = 1, pc_enable = 0, id_ex_flush = 1), then go to RUN. The target is fetched next cycle.
  - branch_taken is ignored in REDIRECT, because EX holds a bubble.
- Watchdog:
  - A 16-bit counter increments each cycle either busywait is high and clears on any cycle where both are low.
  - When the counter reaches TIMEOUT_CYCLES: timeout_err = 1 (sticky), next state = FAULT.
- FAULT: all enables = 0, no flushes, seq_state = 4. Held until reset.
- Reset asserted in any state, including mid-REDIRECT or FAULT, gives the full reset values in the next cycle.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN, when defined, adds three CNT_W-bit outputs, each reset to 0 and saturating at all ones:
  - stall_cycles: increments on any cycle with pc_enable=0 outside reset and FAULT
  - flush_events: increments on any cycle with if_id_flush=1 outside reset
  - load_use_count: increments on each cycle the load-use stall is applied
- When the macro is undefined, these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset held 2 cycles, then released with all inputs 0: enables = 0 and both flushes = 1 during reset; the first cycle after reset has all enables = 1, flushes = 0, seq_state = 0.
- load_use_hazard pulsed 1 cycle: that cycle pc_enable = if_id_enable = 0, id_ex_flush = 1, ex_mem_enable = 1; the next cycle is all enabled.
- dmem_busywait held 3 cycles with branch_taken=1 throughout: 3 cycles of all enables = 0 and seq_state = 2, then one cycle with both flushes = 1, then seq_state = 0.
- branch_taken together with imem_busywait, which stays high for 2 more cycles: PC loads, seq_state = 3; 2 cycles of pc_enable = 0 with id_ex_flush = 1; then one cycle of if_id_flush = 1, pc_enable = 0; then RUN.
- TIMEOUT_CYCLES=4 with imem_busywait stuck at 1: timeout_err rises after the 4th cycle, seq_state = 4, all enables = 0; reset clears timeout_err to 0.
- HAZARD_PERF_CNT_EN defined, 3 load-use pulses and 1 branch: load_use_count = 3, flush_events = 1, stall_cycles = 3.
